// File: rtl/seven_seg_scanner_if.sv
// Display-side bundle of the seven-segment scanner: BCD time in, active-low drive out.
interface seven_seg_scanner_if;
    logic [23:0] number;
    logic [5:0]  blink_mask;
    logic        lz_en;
    logic [7:0]  an;
    logic [6:0]  seg;
    logic        dp;

    modport master (
        output number, blink_mask, lz_en,
        input  an, seg, dp
    );

    modport slave (
        input  number, blink_mask, lz_en,
        output an, seg, dp
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed 6-of-8 digit common-anode driver for a packed BCD HH:MM:SS word,
// with per-slot anti-ghost blanking, separator dots, blinking and leading-zero suppression.
module seven_seg_scanner #(
    parameter int unsigned SCAN_DIV     = 100000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned BLINK_DIV    = 25000000
) (
    input  logic               clk,
    input  logic               rst,
    seven_seg_scanner_if.slave disp
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(BLINK_DIV - 1);

    typedef enum logic [2:0] {
        DIG0 = 3'd0,
        DIG1 = 3'd1,
        DIG2 = 3'd2,
        DIG3 = 3'd3,
        DIG4 = 3'd4,
        DIG5 = 3'd5
    } digit_e;

    digit_e            digit_q, digit_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [23:0]       snap_q, snap_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic              ph_q, ph_d;
    logic [7:0]        an_q, an_d;
    logic [6:0]        seg_q, seg_d;
    logic              dp_q, dp_d;

    logic [2:0]        dig_idx;
    logic [3:0]        digit_val;
    logic              blink_hide;
    logic              lz_hide;
    logic              en;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] val);
        logic [6:0] s;
        case (val)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h3F;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q <= DIG0;
            cnt_q   <= '0;
            snap_q  <= '0;
            blk_q   <= '0;
            ph_q    <= 1'b0;
            an_q    <= 8'hFF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            digit_q <= digit_d;
            cnt_q   <= cnt_d;
            snap_q  <= snap_d;
            blk_q   <= blk_d;
            ph_q    <= ph_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end

    // Slot/digit sequencer; the snapshot is taken only at the frame boundary so a frame never tears.
    always_comb begin
        cnt_d   = cnt_q;
        digit_d = digit_q;
        snap_d  = snap_q;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
            case (digit_q)
                DIG0:    digit_d = DIG1;
                DIG1:    digit_d = DIG2;
                DIG2:    digit_d = DIG3;
                DIG3:    digit_d = DIG4;
                DIG4:    digit_d = DIG5;
                DIG5: begin
                    digit_d = DIG0;
                    snap_d  = disp.number;
                end
                default: digit_d = DIG0;
            endcase
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Free-running blink phase generator.
    always_comb begin
        blk_d = blk_q;
        ph_d  = ph_q;
        if (blk_q == BLK_LAST) begin
            blk_d = '0;
            ph_d  = ~ph_q;
        end else begin
            blk_d = blk_q + BLK_W'(1);
        end
    end

    always_comb begin
        dig_idx    = digit_q;
        digit_val  = snap_q[{dig_idx, 2'b00} +: 4];
        blink_hide = ph_q && disp.blink_mask[dig_idx];
        lz_hide    = disp.lz_en && (digit_q == DIG5) && (snap_q[23:20] == 4'h0);
        en         = (cnt_q >= CNT_BLANK) && !blink_hide && !lz_hide;

        an_d  = 8'hFF;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (en) begin
            an_d  = ~(8'h01 << dig_idx);
            seg_d = seg_decode(digit_val);
            dp_d  = !((digit_q == DIG2) || (digit_q == DIG4));
        end
    end

    assign disp.an  = an_q;
    assign disp.seg = seg_q;
    assign disp.dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Scoreboard bench for seven_seg_scanner: a cycle model queues expected outputs, checked one cycle later.
module tb_seven_seg_scanner;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned BLANK_CYCLES = 1;
    localparam int unsigned BLINK_DIV    = 64;

    logic clk;
    logic rst;

    seven_seg_scanner_if dif ();

    seven_seg_scanner #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES),
        .BLINK_DIV    (BLINK_DIV)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .disp (dif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};

    // Reference model state
    int          m_cnt  = 0;
    int          m_d    = 0;
    logic [23:0] m_snap = '0;
    int          m_bcnt = 0;
    bit          m_ph   = 1'b0;
    logic [15:0] exp_q [$];

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_cnt  = 0;
                m_d    = 0;
                m_snap = '0;
                m_bcnt = 0;
                m_ph   = 1'b0;
                exp_q.delete();
            end else begin
                logic       e;
                logic [3:0] dv;
                logic [7:0] ea;
                logic [6:0] es;
                logic       ed;
                e  = (m_cnt >= int'(BLANK_CYCLES)) && !(m_ph && dif.blink_mask[m_d])
                     && !(dif.lz_en && m_d == 5 && m_snap[23:20] == 4'h0);
                dv = m_snap[4*m_d +: 4];
                ea = e ? ~(8'h01 << m_d) : 8'hFF;
                es = e ? seg_tab[dv] : 7'h7F;
                ed = (e && (m_d == 2 || m_d == 4)) ? 1'b0 : 1'b1;
                exp_q.push_back({ea, es, ed});
                if (m_cnt == int'(SCAN_DIV) - 1) begin
                    m_cnt = 0;
                    if (m_d == 5) begin
                        m_snap = dif.number;
                        m_d    = 0;
                    end else begin
                        m_d = m_d + 1;
                    end
                end else begin
                    m_cnt = m_cnt + 1;
                end
                if (m_bcnt == int'(BLINK_DIV) - 1) begin
                    m_bcnt = 0;
                    m_ph   = !m_ph;
                end else begin
                    m_bcnt = m_bcnt + 1;
                end
            end
        end
    end

    // Scoreboard pop plus per-cycle anode invariants, sampled mid-cycle
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                check_eq("an_in_reset", 32'(dif.an), 32'hFF);
            end else begin
                check_eq("an_one_low", 32'($countones(~dif.an) <= 1), 32'd1);
                check_eq("an_hi_off", 32'(dif.an[7:6]), 32'h3);
                if (exp_q.size() > 0) begin
                    logic [15:0] x;
                    x = exp_q.pop_front();
                    check_eq("sb_an", 32'(dif.an), 32'(x[15:8]));
                    check_eq("sb_seg", 32'(dif.seg), 32'(x[7:1]));
                    check_eq("sb_dp", 32'(dif.dp), 32'(x[0]));
                end
            end
        end
    end

    task automatic wait_slot(input int k);
        bit found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            if (dif.an == ~(8'h01 << k)) found = 1'b1;
        end
        if (!found) check_eq("slot_timeout", 32'(k), 32'hFFFF);
    endtask

    task automatic expect_slot(input int k, input logic [6:0] s);
        wait_slot(k);
        check_eq($sformatf("d%0d_seg", k), 32'(dif.seg), 32'(s));
        check_eq($sformatf("d%0d_dp", k), 32'(dif.dp), (k == 2 || k == 4) ? 32'd0 : 32'd1);
    endtask

    initial begin
        int c_a, c_b;
        rst            = 1'b1;
        dif.number     = '0;
        dif.blink_mask = '0;
        dif.lz_en      = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_an", 32'(dif.an), 32'hFF);
        check_eq("rst_seg", 32'(dif.seg), 32'h7F);
        check_eq("rst_dp", 32'(dif.dp), 32'h1);
        rst        = 1'b0;
        dif.number = 24'h123456;

        // Frame 1 shows the reset snapshot, frame 2 the new time
        for (int k = 0; k < 6; k++) expect_slot(k, 7'h40);
        expect_slot(0, 7'h02);
        expect_slot(1, 7'h12);
        expect_slot(2, 7'h19);
        expect_slot(3, 7'h30);
        expect_slot(4, 7'h24);
        expect_slot(5, 7'h79);

        // Mid-frame change must not tear the frame
        dif.number = 24'h235959;
        wait_slot(5);
        expect_slot(0, 7'h10);
        expect_slot(1, 7'h12);
        expect_slot(2, 7'h10);
        dif.number = 24'h000000;
        expect_slot(3, 7'h12);
        expect_slot(4, 7'h30);
        expect_slot(5, 7'h24);
        expect_slot(0, 7'h40);

        // Leading-zero suppression
        dif.number = 24'h075959;
        wait_slot(5);
        expect_slot(4, 7'h78);
        expect_slot(5, 7'h40);
        dif.lz_en = 1'b1;
        c_a = 0;
        c_b = 0;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (dif.an == 8'hDF) c_a++;
            if (dif.an == 8'hEF) c_b++;
        end
        check_eq("lz_d5_lit", 32'(c_a), 32'd0);
        check_eq("lz_d4_lit", 32'(c_b), 32'd6);

        // Dash for non-decimal code
        dif.lz_en  = 1'b0;
        dif.number = 24'h00000A;
        wait_slot(5);
        expect_slot(0, 7'h3F);

        // Blinking of digits 4 and 5
        dif.blink_mask = 6'b110000;
        c_a = 0;
        c_b = 0;
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            if (dif.an == 8'hEF) c_a++;
            if (dif.an == 8'hFE) c_b++;
        end
        check_eq("blink_d4_dimmer", 32'(c_a < c_b), 32'd1);
        check_eq("blink_d4_some", 32'(c_a > 0), 32'd1);
        dif.blink_mask = '0;

        // Async reset mid-slot
        wait_slot(3);
        rst = 1'b1;
        #1;
        check_eq("arst_an", 32'(dif.an), 32'hFF);
        check_eq("arst_seg", 32'(dif.seg), 32'h7F);
        check_eq("arst_dp", 32'(dif.dp), 32'h1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) expect_slot(k, 7'h40);
        expect_slot(0, 7'h3F);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
